cornice_motion_ctrl: RTL
========================

# cornice_motion_ctrl

Frame-synchronous motion controller for the framed rectangle drawn on the 1280x1024 VGA output. Once per frame, at the vertical-sync boundary, it computes the next top-left corner of the rectangle. There are two modes: manual (button-driven, wrap-around) and automatic bounce (constant velocity, reflection at screen edges). It replaces ad-hoc per-VS position logic. It feeds posx/posy to the frame/interior hit-test and to the BCD display path.

## Interface
- H, 1280, horizontal active pixels
- V, 1024, vertical active lines
- LARGHEZZA, 400, rectangle width in pixels
- ALTEZZA, 300, rectangle height in lines
- VGA_CLK  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high; clears all state
- VGA_VS  in  1  vertical sync from the VGA timing block; frame boundary is its rising edge
- auto_mode  in  1  1 = bounce mode, 0 = manual mode
- btn_x, btn_y  in  1 each  manual move requests, active-low (KEY style)
- dir_x, dir_y  in  1 each  manual direction; 1 = increment
- step  in  4  pixels per frame, applied on both axes; 0 = frozen
- posx, posy  out  11 each  rectangle top-left corner
- frame_upd  out  1  one-cycle pulse when a new posx/posy pair is committed
- hit  out  2  {hit_y, hit_x}; edge-reflection flags, valid only with frame_upd

## Operation
- Derived limits: XMAX = H-LARGHEZZA = 880; YMAX = V-ALTEZZA = 724. Invariant: 0 <= posx <= XMAX and 0 <= posy <= YMAX at all times.
- Reset values:
  - posx = H/2-LARGHEZZA/2 = 440; posy = V/2-ALTEZZA/2 = 362.
  - Velocity signs vx = vy = +.
  - frame_upd = 0; hit = 0; FSM in WAIT.
- FSM states: WAIT → CALC_X → CALC_Y → COMMIT → WAIT.
  - WAIT: leaves only when a synchronized VS rising edge is detected.
  - CALC_X and CALC_Y: unconditional, one cycle each.
  - VS edges arriving outside WAIT are dropped, so there is at most one update per frame.
- All arithmetic is 12-bit unsigned with an explicit borrow/overflow compare. No result may wrap silently outside [0, XMAX]/[0, YMAX].
- Manual mode (auto_mode = 0), per axis:
  - Button not pressed: position unchanged.
  - Pressed, dir = 1: pos+step > MAX gives 0 (wrap); otherwise pos+step.
  - Pressed, dir = 0: pos < step gives MAX (wrap); otherwise pos-step.
  - hit is always 0.
- Auto mode (auto_mode = 1), per axis:
  - Sign +: if pos+step >= MAX, pos = MAX, sign flips to -, hit bit set. Otherwise pos+step.
  - Sign -: if pos <= step, pos = 0, sign flips to +, hit bit set. Otherwise pos-step.
  - Buttons are ignored.
- step = 0 in either mode: no movement, no sign flip, hit = 0. frame_upd still pulses.
- Sign registers persist across mode changes.
- auto_mode, btn_*, dir_* and step are sampled in CALC_X/CALC_Y only. A change takes effect on the next frame.
- CALC results go to shadow registers. posx/posy load together in COMMIT, so downstream never sees a mixed pair.

## Timing
- VGA_VS goes through a 2-FF synchronizer, then a registered rising-edge detector. The detected pulse is high for exactly one cycle (E).
- Edge detected in cycle E (FSM in WAIT):
  - CALC_X in E+1.
  - CALC_Y in E+2.
  - COMMIT in E+3.
  - posx, posy, hit and frame_upd update on the clock edge ending E+3.
  - frame_upd is high for the single cycle E+4.
- Pin-to-output latency, VS rise to new position: 6 clock edges.
- hit is held until the next COMMIT. It is meaningful only while frame_upd = 1.
- reset asserted in any state: all outputs take their reset values immediately, without waiting for a clock. The FSM returns to WAIT and synchronizer flops clear. An in-flight calculation is discarded with no frame_upd.
- After reset deasserts, the first VS edge is detected normally. A VS level already high at release is not a rising edge.

## Structure
- Package cornice_pkg holds:
  - H, V, LARGHEZZA, ALTEZZA and derived XMAX/YMAX.
  - Coordinate width (11).
  - The FSM state enum (WAIT, CALC_X, CALC_Y, COMMIT).
- Sub-module sincronizza_fronte: 2-FF synchronizer plus rising-edge pulse. It has its own async active-high reset and is reused for other asynchronous inputs later.
- The per-axis next-position function is shared by both axes. It is parameterized on MAX, not duplicated by hand.

## Test plan
- Reset, then release:
  - Required: posx = 440, posy = 362, frame_upd = 0, hit = 0, with no VS activity.
  - Assert reset mid-CALC_Y: same values immediately, no frame_upd pulse.
- Manual, step = 4, btn_x low, dir_x = 1, 110 VS pulses:
  - posx reaches 880.
  - Next pulse: posx = 0 (wrap), hit = 0, posy unchanged at 362.
- Auto, step = 4 from reset, posx trajectory:
  - After 110 frames: posx = 880 with hit_x = 1 on that frame_upd.
  - Frame 111: posx = 876, hit_x = 0.
  - posy follows with hit_y at frame 91 (posy = 724).
- Auto, step = 0 over 5 frames:
  - Position and signs unchanged, hit = 0.
  - frame_upd pulses 5 times, each exactly 6 edges after its VS rise.
- Change auto_mode and step in cycle E+2 (during CALC_Y):
  - The committed result uses the values sampled in CALC_X/CALC_Y as specified.
  - A second VS edge injected during CALC_Y is dropped: exactly one frame_upd.

Source files
------------

// File: rtl/cornice_pkg.sv
// Shared constants, FSM encoding and the per-axis next-position function
// for the cornice rectangle motion controller.
//   H, V               : active screen size (pixels, lines)
//   LARGHEZZA, ALTEZZA : rectangle size
//   XMAX, YMAX         : largest legal top-left coordinate per axis
//   COORD_W            : coordinate width
//   next_axis()        : one axis step, limit passed in as an argument
package cornice_pkg;

  localparam int H         = 1280;
  localparam int V         = 1024;
  localparam int LARGHEZZA = 400;
  localparam int ALTEZZA   = 300;
  localparam int XMAX      = H - LARGHEZZA;
  localparam int YMAX      = V - ALTEZZA;
  localparam int POSX_RST  = H/2 - LARGHEZZA/2;
  localparam int POSY_RST  = V/2 - ALTEZZA/2;
  localparam int COORD_W   = 11;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_CALC_X = 2'd1;
  localparam logic [1:0] ST_CALC_Y = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               sign;   // 1 = moving towards larger coordinates
    logic               hit;
  } axis_t;

  // All math is done on 12 bits so that pos+step never wraps, and the
  // subtraction is only used after the explicit pos < step compare.
  function automatic axis_t next_axis(
    input logic [COORD_W-1:0] pos,
    input logic               sign,
    input logic               auto_mode,
    input logic               btn_n,
    input logic               dir,
    input logic [3:0]         step,
    input logic [11:0]        max
  );
    axis_t       r;
    logic [11:0] p12;
    logic [11:0] s12;
    logic [11:0] sum;
    logic [11:0] diff;
    p12   = {1'b0, pos};
    s12   = {8'd0, step};
    sum   = p12 + s12;
    diff  = p12 - s12;
    r.pos  = pos;
    r.sign = sign;
    r.hit  = 1'b0;
    if (step != 4'd0) begin
      if (!auto_mode) begin
        if (!btn_n) begin
          if (dir) r.pos = (sum > max) ? '0 : sum[COORD_W-1:0];
          else     r.pos = (p12 < s12) ? max[COORD_W-1:0] : diff[COORD_W-1:0];
        end
      end else if (sign) begin
        if (sum >= max) begin
          r.pos  = max[COORD_W-1:0];
          r.sign = 1'b0;
          r.hit  = 1'b1;
        end else begin
          r.pos = sum[COORD_W-1:0];
        end
      end else begin
        if (p12 <= s12) begin
          r.pos  = '0;
          r.sign = 1'b1;
          r.hit  = 1'b1;
        end else begin
          r.pos = diff[COORD_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sincronizza_fronte.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   din  : asynchronous input
//   rise : one-cycle pulse on a synchronized 0->1 transition
module sincronizza_fronte (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] warm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      warm <= {warm[1:0], 1'b1};
    end
  end

  // The cleared flops would otherwise fake an edge when din is already high
  // at reset release; edges count only once s3 holds a real sample.
  assign rise = warm[2] & s2 & ~s3;

endmodule

// File: rtl/cornice_motion_ctrl.sv
// Frame-synchronous position controller for the framed rectangle.
// Computes the next top-left corner once per VS rising edge, in manual
// (wrap-around) or automatic bounce mode.
//   VGA_CLK, reset           : pixel clock, async active-high reset
//   VGA_VS                   : vertical sync, frame boundary on rising edge
//   auto_mode                : 1 = bounce, 0 = manual
//   btn_x/btn_y (active low) : manual move requests; dir_x/dir_y 1 = increment
//   step                     : pixels per frame on both axes
//   posx, posy               : committed top-left corner
//   frame_upd                : one-cycle pulse after a commit
//   hit                      : {hit_y, hit_x} reflection flags of last commit
module cornice_motion_ctrl
  import cornice_pkg::*;
(
  input  logic               VGA_CLK,
  input  logic               reset,
  input  logic               VGA_VS,
  input  logic               auto_mode,
  input  logic               btn_x,
  input  logic               btn_y,
  input  logic               dir_x,
  input  logic               dir_y,
  input  logic [3:0]         step,
  output logic [COORD_W-1:0] posx,
  output logic [COORD_W-1:0] posy,
  output logic               frame_upd,
  output logic [1:0]         hit
);

  localparam logic [11:0] XMAX12 = 12'(XMAX);
  localparam logic [11:0] YMAX12 = 12'(YMAX);

  logic               vs_rise;
  logic [1:0]         state;
  logic               sign_x;
  logic               sign_y;
  logic [COORD_W-1:0] sh_x;
  logic [COORD_W-1:0] sh_y;
  logic               sh_sign_x;
  logic               sh_sign_y;
  logic               sh_hit_x;
  logic               sh_hit_y;
  axis_t              nx;
  axis_t              ny;

  sincronizza_fronte u_sync (
    .clk  (VGA_CLK),
    .rst  (reset),
    .din  (VGA_VS),
    .rise (vs_rise)
  );

  // Each axis only uses its result in its own CALC state, so the inputs are
  // effectively sampled there.
  assign nx = next_axis(posx, sign_x, auto_mode, btn_x, dir_x, step, XMAX12);
  assign ny = next_axis(posy, sign_y, auto_mode, btn_y, dir_y, step, YMAX12);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state     <= ST_WAIT;
      posx      <= COORD_W'(POSX_RST);
      posy      <= COORD_W'(POSY_RST);
      sign_x    <= 1'b1;
      sign_y    <= 1'b1;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_sign_x <= 1'b1;
      sh_sign_y <= 1'b1;
      sh_hit_x  <= 1'b0;
      sh_hit_y  <= 1'b0;
      frame_upd <= 1'b0;
      hit       <= '0;
    end else begin
      frame_upd <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (vs_rise) state <= ST_CALC_X;
        end
        ST_CALC_X: begin
          sh_x      <= nx.pos;
          sh_sign_x <= nx.sign;
          sh_hit_x  <= nx.hit;
          state     <= ST_CALC_Y;
        end
        ST_CALC_Y: begin
          sh_y      <= ny.pos;
          sh_sign_y <= ny.sign;
          sh_hit_y  <= ny.hit;
          state     <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Both coordinates load on the same edge: no mixed pair downstream.
          posx      <= sh_x;
          posy      <= sh_y;
          sign_x    <= sh_sign_x;
          sign_y    <= sh_sign_y;
          hit       <= {sh_hit_y, sh_hit_x};
          frame_upd <= 1'b1;
          state     <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule
